// File: rtl/mem_arb_pkg.sv
// Shared types, default widths and the winner-pick function for mem_arbiter.
package mem_arb_pkg;

   typedef enum logic {Idle = 1'b0, Grant = 1'b1} arb_state_t;

   localparam int AW          = 24;
   localparam int DW          = 16;
   localparam int MAX_CLIENTS = 8;

   // First requesting client found scanning upward from ptr, wrapping modulo n.
   function automatic int arb_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
      int         win;
      logic       found;
      logic [2:0] idx;
      win   = 0;
      found = 1'b0;
      for (int i = 0; i < MAX_CLIENTS; i++) begin
         idx = 3'((int'(ptr) + i) % n);
         if ((i < n) && !found && req[idx]) begin
            win   = int'(idx);
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// Read-tag FIFO for mem_arbiter: holds the issuing client of every outstanding read in issue order.
module mem_arb_tag_fifo
   import mem_arb_pkg::*;
#(
   parameter int TAGS = 4,
   parameter int W    = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int PW = $clog2(TAGS) + 1;
   localparam int IW = PW - 1;

   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [W-1:0]  store_r [TAGS];
   logic          do_push_s;
   logic          do_pop_s;

   // Status flags and head read; a push into a full FIFO is legal only alongside a pop.
   always_comb begin
      full      = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) && (wr_ptr_r[IW-1:0] == rd_ptr_r[IW-1:0]);
      empty     = (wr_ptr_r == rd_ptr_r);
      dout      = store_r[rd_ptr_r[IW-1:0]];
      do_push_s = push && (!full || pop);
      do_pop_s  = pop && !empty;
   end

   // Pointer and storage update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         for (int i = 0; i < TAGS; i++) begin
            store_r[i] <= '0;
         end
      end else begin
         if (do_push_s) begin
            store_r[wr_ptr_r[IW-1:0]] <= din;
            wr_ptr_r                  <= wr_ptr_r + PW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// N-client SDRAM request arbiter with read-return steering via a tag FIFO.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int N    = 4,
   parameter int AW   = mem_arb_pkg::AW,
   parameter int DW   = mem_arb_pkg::DW,
   parameter int TAGS = 4
) (
   input  logic          clkSYS,
   input  logic          reset,
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  wr,
   input  logic [N*AW-1:0] addr,
   input  logic [N*DW-1:0] data,
   output logic [N-1:0]  ack,
   output logic [DW-1:0] mem,
   output logic [N-1:0]  valid,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_data,
   output logic          m_wr,
   output logic          m_req,
   input  logic          m_ack,
   input  logic [DW-1:0] m_rdata,
   input  logic          m_rvalid,
   output logic          busy,
   output logic          err
);

   localparam int GW = $clog2(N);

   arb_state_t    state_r;
   arb_state_t    state_nxt_s;
   logic [GW-1:0] gnt_r;
   logic [GW-1:0] gnt_nxt_s;
   logic          sel_req_s;
   logic          sel_wr_s;
   logic          stall_s;
   logic          accept_s;
   logic          tag_push_s;
   logic          tag_pop_s;
   logic [GW-1:0] tag_dout_s;
   logic          tag_full_s;
   logic          tag_empty_s;
   logic [N-1:0]  valid_r;
   logic [DW-1:0] mem_r;
   logic          err_r;
`ifdef MEM_ARB_RR_EN
   logic [GW-1:0] ptr_r;
`endif

   // Controller-side mux and handshake; a read is held off while every tag is in use.
   always_comb begin
      sel_req_s  = req[gnt_r];
      sel_wr_s   = wr[gnt_r];
      stall_s    = tag_full_s && !sel_wr_s;
      m_req      = 1'b0;
      m_wr       = 1'b0;
      m_addr     = '0;
      m_data     = '0;
      ack        = '0;
      if (state_r == Grant) begin
         m_req  = sel_req_s && !stall_s;
         m_wr   = sel_wr_s;
         m_addr = addr[gnt_r*AW +: AW];
         m_data = data[gnt_r*DW +: DW];
      end else begin
         m_req  = 1'b0;
      end
      accept_s   = m_req && m_ack;
      if (accept_s) begin
         ack[gnt_r] = 1'b1;
      end else begin
         ack = '0;
      end
      tag_push_s = accept_s && !sel_wr_s;
      tag_pop_s  = m_rvalid && !tag_empty_s;
   end

   // Next-state and winner selection.
   always_comb begin
      state_nxt_s = state_r;
      gnt_nxt_s   = gnt_r;
      case (state_r)
         Idle: begin
            if (|req) begin
               state_nxt_s = Grant;
`ifdef MEM_ARB_RR_EN
               gnt_nxt_s   = GW'(arb_pick(8'(req), 3'(ptr_r), N));
`else
               gnt_nxt_s   = GW'(arb_pick(8'(req), 3'd0, N));
`endif
            end else begin
               state_nxt_s = Idle;
            end
         end
         Grant: begin
            if (accept_s || !sel_req_s) begin
               state_nxt_s = Idle;
            end else begin
               state_nxt_s = Grant;
            end
         end
         default: begin
            state_nxt_s = Idle;
         end
      endcase
   end

   // FSM state and registered grant index.
   always_ff @(posedge clkSYS or posedge reset) begin
      if (reset) begin
         state_r <= Idle;
         gnt_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         gnt_r   <= gnt_nxt_s;
      end
   end

`ifdef MEM_ARB_RR_EN
   // Round-robin pointer moves just past the client that was accepted.
   always_ff @(posedge clkSYS or posedge reset) begin
      if (reset) begin
         ptr_r <= '0;
      end else if (accept_s) begin
         ptr_r <= (gnt_r == GW'(N - 1)) ? '0 : gnt_r + GW'(1);
      end
   end
`endif

   // Read return steering and sticky orphan-return error.
   always_ff @(posedge clkSYS or posedge reset) begin
      if (reset) begin
         valid_r <= '0;
         mem_r   <= '0;
         err_r   <= 1'b0;
      end else begin
         valid_r <= '0;
         if (tag_pop_s) begin
            valid_r <= N'(1) << tag_dout_s;
            mem_r   <= m_rdata;
         end
         if (m_rvalid && tag_empty_s) begin
            err_r <= 1'b1;
         end
      end
   end

   assign valid = valid_r;
   assign mem   = mem_r;
   assign err   = err_r;
   assign busy  = (state_r == Grant) || !tag_empty_s;

   mem_arb_tag_fifo #(
      .TAGS (TAGS),
      .W    (GW)
   ) u_tag_fifo (
      .clk   (clkSYS),
      .rst   (reset),
      .push  (tag_push_s),
      .pop   (tag_pop_s),
      .din   (gnt_r),
      .dout  (tag_dout_s),
      .full  (tag_full_s),
      .empty (tag_empty_s)
   );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (N=4, AW=24, DW=16, TAGS=4).
module tb_mem_arbiter;

   localparam int N    = 4;
   localparam int AW   = 24;
   localparam int DW   = 16;
   localparam int TAGS = 4;

   logic          clk_sys = 1'b0;
   logic          reset;
   logic [N-1:0]  req;
   logic [N-1:0]  wr;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] data;
   logic [N-1:0]  ack;
   logic [DW-1:0] mem;
   logic [N-1:0]  valid;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic          m_wr;
   logic          m_req;
   logic          m_ack;
   logic [DW-1:0] m_rdata;
   logic          m_rvalid;
   logic          busy;
   logic          err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_sys = ~clk_sys;

   mem_arbiter #(.N(N), .AW(AW), .DW(DW), .TAGS(TAGS)) dut (
      .clkSYS   (clk_sys),
      .reset    (reset),
      .req      (req),
      .wr       (wr),
      .addr     (addr),
      .data     (data),
      .ack      (ack),
      .mem      (mem),
      .valid    (valid),
      .m_addr   (m_addr),
      .m_data   (m_data),
      .m_wr     (m_wr),
      .m_req    (m_req),
      .m_ack    (m_ack),
      .m_rdata  (m_rdata),
      .m_rvalid (m_rvalid),
      .busy     (busy),
      .err      (err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic read_txn(input int c, input logic [23:0] a);
      logic [3:0] e;
      e = 4'b0001 << c;
      req[c] = 1'b1;
      wr[c]  = 1'b0;
      addr[c*AW +: AW] = a;
      tick();
      check_eq("rd_mreq", 32'(m_req), 32'd1);
      check_eq("rd_maddr", 32'(m_addr), 32'(a));
      m_ack = 1'b1;
      settle();
      check_eq("rd_ack", 32'(ack), 32'(e));
      tick();
      m_ack  = 1'b0;
      req[c] = 1'b0;
   endtask

   initial begin
      int         exp_g [5];
      int         exp_t [4];
      logic [3:0] e;
`ifdef MEM_ARB_RR_EN
      exp_g = '{0, 1, 2, 3, 0};
`else
      exp_g = '{0, 0, 0, 0, 0};
`endif
      exp_t = '{1, 2, 3, 0};

      reset    = 1'b1;
      req      = '0;
      wr       = '0;
      addr     = '0;
      data     = '0;
      m_ack    = 1'b0;
      m_rdata  = '0;
      m_rvalid = 1'b0;
      tick();
      tick();
      check_eq("rst_ack", 32'(ack), 32'd0);
      check_eq("rst_valid", 32'(valid), 32'd0);
      check_eq("rst_mreq", 32'(m_req), 32'd0);
      check_eq("rst_mwr", 32'(m_wr), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_err", 32'(err), 32'd0);
      check_eq("rst_maddr", 32'(m_addr), 32'd0);
      check_eq("rst_mdata", 32'(m_data), 32'd0);
      check_eq("rst_mem", 32'(mem), 32'd0);
      reset = 1'b0;
      tick();

      // Single write from client 2
      req[2] = 1'b1;
      wr[2]  = 1'b1;
      addr[2*AW +: AW] = 24'h080010;
      data[2*DW +: DW] = 16'h667f;
      settle();
      check_eq("wr_mreq_t0", 32'(m_req), 32'd0);
      tick();
      check_eq("wr_mreq_t1", 32'(m_req), 32'd1);
      check_eq("wr_maddr", 32'(m_addr), 32'h080010);
      check_eq("wr_mdata", 32'(m_data), 32'h667f);
      check_eq("wr_mwr", 32'(m_wr), 32'd1);
      check_eq("wr_busy", 32'(busy), 32'd1);
      tick();
      check_eq("wr_ack_t2", 32'(ack), 32'd0);
      tick();
      m_ack = 1'b1;
      settle();
      check_eq("wr_ack_t3", 32'(ack), 32'h4);
      tick();
      m_ack  = 1'b0;
      req[2] = 1'b0;
      settle();
      check_eq("wr_ack_after", 32'(ack), 32'd0);
      check_eq("wr_busy_after", 32'(busy), 32'd0);

      // Read routing, with client 3's push coinciding with client 1's pop
      read_txn(1, 24'h000004);
      req[3] = 1'b1;
      wr[3]  = 1'b0;
      addr[3*AW +: AW] = 24'h000008;
      tick();
      check_eq("rr_maddr3", 32'(m_addr), 32'h000008);
      m_ack    = 1'b1;
      m_rvalid = 1'b1;
      m_rdata  = 16'h1234;
      settle();
      check_eq("rr_ack3", 32'(ack), 32'h8);
      tick();
      m_ack    = 1'b0;
      m_rvalid = 1'b0;
      req[3]   = 1'b0;
      check_eq("rr_valid1", 32'(valid), 32'h2);
      check_eq("rr_mem1", 32'(mem), 32'h1234);
      check_eq("rr_busy", 32'(busy), 32'd1);
      tick();
      check_eq("rr_valid_gap", 32'(valid), 32'd0);
      check_eq("rr_mem_hold", 32'(mem), 32'h1234);
      m_rvalid = 1'b1;
      m_rdata  = 16'hbeef;
      tick();
      m_rvalid = 1'b0;
      check_eq("rr_valid3", 32'(valid), 32'h8);
      check_eq("rr_mem3", 32'(mem), 32'hbeef);
      tick();
      check_eq("rr_valid_end", 32'(valid), 32'd0);
      check_eq("rr_busy_end", 32'(busy), 32'd0);

      // Arbitration with all four clients writing continuously
      for (int i = 0; i < N; i++) begin
         addr[i*AW +: AW] = 24'h100000 + 24'(i);
      end
      wr  = 4'hf;
      req = 4'hf;
      for (int k = 0; k < 5; k++) begin
         tick();
         check_eq("arb_mreq", 32'(m_req), 32'd1);
         check_eq("arb_maddr", 32'(m_addr), 32'h100000 + 32'(exp_g[k]));
         m_ack = 1'b1;
         settle();
         e = 4'b0001 << exp_g[k];
         check_eq("arb_ack", 32'(ack), 32'(e));
         tick();
         if (k == 4) begin
            req = 4'h0;
         end
         settle();
         check_eq("arb_idle_ack", 32'(ack), 32'd0);
         m_ack = 1'b0;
      end
      tick();
      wr = 4'h0;
      check_eq("arb_busy_end", 32'(busy), 32'd0);

      // Tag FIFO full: four unreturned reads, then a stalled fifth
      for (int c = 0; c < N; c++) begin
         read_txn(c, 24'h000200 + 24'(c));
      end
      req[0] = 1'b1;
      wr[0]  = 1'b0;
      addr[0 +: AW] = 24'h000100;
      tick();
      check_eq("full_stall0", 32'(m_req), 32'd0);
      check_eq("full_busy", 32'(busy), 32'd1);
      tick();
      check_eq("full_stall1", 32'(m_req), 32'd0);
      m_rvalid = 1'b1;
      m_rdata  = 16'ha001;
      settle();
      check_eq("full_stall_pop", 32'(m_req), 32'd0);
      tick();
      m_rvalid = 1'b0;
      check_eq("full_valid0", 32'(valid), 32'h1);
      check_eq("full_mem0", 32'(mem), 32'ha001);
      check_eq("full_release", 32'(m_req), 32'd1);
      check_eq("full_maddr", 32'(m_addr), 32'h000100);
      m_ack = 1'b1;
      settle();
      check_eq("full_ack", 32'(ack), 32'h1);
      tick();
      m_ack  = 1'b0;
      req[0] = 1'b0;
      req[1] = 1'b1;
      wr[1]  = 1'b0;
      tick();
      check_eq("full_again", 32'(m_req), 32'd0);
      req[1] = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
         m_rvalid = 1'b1;
         m_rdata  = 16'hb000 | 16'(k);
         tick();
         e = 4'b0001 << exp_t[k];
         check_eq("drain_valid", 32'(valid), 32'(e));
         check_eq("drain_mem", 32'(mem), 32'hb000 | 32'(k));
      end
      m_rvalid = 1'b0;
      tick();
      check_eq("drain_valid_end", 32'(valid), 32'd0);
      check_eq("drain_busy", 32'(busy), 32'd0);
      check_eq("drain_err", 32'(err), 32'd0);

      // Abandoned request, then a stray return
      req[1] = 1'b1;
      wr[1]  = 1'b1;
      tick();
      check_eq("ab_mreq", 32'(m_req), 32'd1);
      req[1] = 1'b0;
      m_ack  = 1'b1;
      settle();
      check_eq("ab_mreq_drop", 32'(m_req), 32'd0);
      check_eq("ab_ack", 32'(ack), 32'd0);
      tick();
      m_ack = 1'b0;
      check_eq("ab_busy", 32'(busy), 32'd0);
      m_rvalid = 1'b1;
      m_rdata  = 16'hdead;
      tick();
      m_rvalid = 1'b0;
      check_eq("stray_err", 32'(err), 32'd1);
      check_eq("stray_valid", 32'(valid), 32'd0);
      check_eq("stray_mem", 32'(mem), 32'hb003);
      tick();
      tick();
      check_eq("stray_err_sticky", 32'(err), 32'd1);

      // Reset with two reads outstanding and a write in Grant
      read_txn(2, 24'h000300);
      read_txn(3, 24'h000304);
      req[0] = 1'b1;
      wr[0]  = 1'b1;
      addr[0 +: AW] = 24'h00abcd;
      data[0 +: DW] = 16'h5555;
      tick();
      check_eq("mid_mreq", 32'(m_req), 32'd1);
      #3;
      reset = 1'b1;
      #1;
      check_eq("arst_mreq", 32'(m_req), 32'd0);
      check_eq("arst_maddr", 32'(m_addr), 32'd0);
      check_eq("arst_mdata", 32'(m_data), 32'd0);
      check_eq("arst_mwr", 32'(m_wr), 32'd0);
      check_eq("arst_ack", 32'(ack), 32'd0);
      check_eq("arst_valid", 32'(valid), 32'd0);
      check_eq("arst_mem", 32'(mem), 32'd0);
      check_eq("arst_busy", 32'(busy), 32'd0);
      check_eq("arst_err", 32'(err), 32'd0);
      req = 4'h0;
      tick();
      reset = 1'b0;
      tick();
      m_rvalid = 1'b1;
      tick();
      m_rvalid = 1'b0;
      check_eq("post_rst_err", 32'(err), 32'd1);
      check_eq("post_rst_valid", 32'(valid), 32'd0);
      check_eq("post_rst_busy", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
